// File: rtl/cnn_pkg.sv
// Types, default widths and size helpers shared by conv_layer and its sequencer conv_layer_ctrl.
package cnn_pkg;

  localparam int DATA_WIDTH_D  = 8;
  localparam int KDATA_WIDTH_D = 8;
  localparam int KERNEL_SIZE_D = 5;
  localparam int IMGROW_D      = 28;
  localparam int IMGCOL_D      = 28;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_IMG = 3'd1,
    ST_LOAD_KER = 3'd2,
    ST_CONV     = 3'd3,
    ST_DRAIN    = 3'd4,
    ST_FINISH   = 3'd5
  } conv_ctrl_state_t;

  function automatic int orow_c(input int imgrow, input int ksize);
    return imgrow - ksize + 1;
  endfunction

  function automatic int ocol_c(input int imgcol, input int ksize);
    return imgcol - ksize + 1;
  endfunction

  // Index width for a counter over n entries (never zero-width).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_out_serializer.sv
// Walks the conv_layer feature map row-major and presents it as a valid/ready pixel stream.
module conv_out_serializer
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OROW       = 24,
  parameter int OCOL       = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  active,
  input  logic                  out_ready,
  input  logic [DATA_WIDTH-1:0] conv_out [OROW][OCOL],
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  drain_done
);

  localparam int RW = idx_w(OROW);
  localparam int CW = idx_w(OCOL);

  logic [RW-1:0] orow;
  logic [CW-1:0] ocol;
  logic          row_end;
  logic          col_end;
  logic          xfer;

  assign row_end = (orow == RW'(OROW - 1));
  assign col_end = (ocol == CW'(OCOL - 1));
  assign xfer    = active && out_ready;

  // Counters only move on an accepted pixel, so data/last hold still through stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      orow <= '0;
      ocol <= '0;
    end else if (!active) begin
      orow <= '0;
      ocol <= '0;
    end else if (xfer) begin
      if (col_end) begin
        ocol <= '0;
        orow <= row_end ? '0 : orow + 1'b1;
      end else begin
        ocol <= ocol + 1'b1;
      end
    end
  end

  assign out_valid  = active;
  assign out_data   = active ? conv_out[orow][ocol] : '0;
  assign out_last   = active && row_end && col_end;
  assign drain_done = xfer && row_end && col_end;

endmodule

// File: rtl/conv_layer_ctrl.sv
// Sequencer around one conv_layer: loads the image once, then per kernel loads weights, runs, drains.
// Define CONV_CTRL_TIMEOUT_EN to add a watchdog on the CONV wait that flags err and skips that drain.
module conv_layer_ctrl
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_D,
  parameter int KDATA_WIDTH    = KDATA_WIDTH_D,
  parameter int KERNEL_SIZE    = KERNEL_SIZE_D,
  parameter int IMGROW         = IMGROW_D,
  parameter int IMGCOL         = IMGCOL_D,
  parameter int NUM_KERNELS    = 6,
  parameter int TIMEOUT_CYCLES = 20000,
  localparam int OROW          = orow_c(IMGROW, KERNEL_SIZE),
  localparam int OCOL          = ocol_c(IMGCOL, KERNEL_SIZE),
  localparam int KIW           = idx_w(NUM_KERNELS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   pix_in_valid,
  output logic                   pix_in_ready,
  input  logic [DATA_WIDTH-1:0]  pix_in_data,
  input  logic                   k_in_valid,
  output logic                   k_in_ready,
  input  logic [KDATA_WIDTH-1:0] k_in_data,
  output logic [DATA_WIDTH-1:0]  layer_image [IMGROW][IMGCOL],
  output logic [KDATA_WIDTH-1:0] layer_kernel [KERNEL_SIZE][KERNEL_SIZE],
  output logic                   layer_rst,
  input  logic                   layer_done,
  input  logic [DATA_WIDTH-1:0]  layer_conv_out [OROW][OCOL],
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_last,
  output logic [KIW-1:0]         out_kidx,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output conv_ctrl_state_t       state_dbg
);

  localparam int IRW = idx_w(IMGROW);
  localparam int ICW = idx_w(IMGCOL);
  localparam int KSW = idx_w(KERNEL_SIZE);

  conv_ctrl_state_t state, state_nx;
  logic [KIW-1:0]   kidx;
  logic             conv_armed;
  logic             kernel_end;
  logic             last_kernel;
  logic             tmo_hit;
  logic             drain_done;

  // Every stream moves one item on a rising edge where valid && ready; valid never waits on ready.
  logic pix_xfer, k_xfer;
  assign pix_in_ready = (state == ST_LOAD_IMG);
  assign k_in_ready   = (state == ST_LOAD_KER);
  assign pix_xfer     = pix_in_valid && pix_in_ready;
  assign k_xfer       = k_in_valid && k_in_ready;

  logic [IRW-1:0] img_r;
  logic [ICW-1:0] img_c;
  logic           img_last;
  assign img_last = pix_xfer && (img_r == IRW'(IMGROW - 1)) && (img_c == ICW'(IMGCOL - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      img_r <= '0;
      img_c <= '0;
      for (int r = 0; r < IMGROW; r++)
        for (int c = 0; c < IMGCOL; c++)
          layer_image[r][c] <= '0;
    end else if (state != ST_LOAD_IMG) begin
      img_r <= '0;
      img_c <= '0;
    end else if (pix_xfer) begin
      layer_image[img_r][img_c] <= pix_in_data;
      if (img_c == ICW'(IMGCOL - 1)) begin
        img_c <= '0;
        img_r <= img_r + 1'b1;
      end else begin
        img_c <= img_c + 1'b1;
      end
    end
  end

  logic [KSW-1:0] ker_r;
  logic [KSW-1:0] ker_c;
  logic           ker_last;
  assign ker_last = k_xfer && (ker_r == KSW'(KERNEL_SIZE - 1)) && (ker_c == KSW'(KERNEL_SIZE - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ker_r <= '0;
      ker_c <= '0;
      for (int r = 0; r < KERNEL_SIZE; r++)
        for (int c = 0; c < KERNEL_SIZE; c++)
          layer_kernel[r][c] <= '0;
    end else if (state != ST_LOAD_KER) begin
      ker_r <= '0;
      ker_c <= '0;
    end else if (k_xfer) begin
      layer_kernel[ker_r][ker_c] <= k_in_data;
      if (ker_c == KSW'(KERNEL_SIZE - 1)) begin
        ker_c <= '0;
        ker_r <= ker_r + 1'b1;
      end else begin
        ker_c <= ker_c + 1'b1;
      end
    end
  end

  assign last_kernel = (kidx == KIW'(NUM_KERNELS - 1));

  always_comb begin
    state_nx   = state;
    kernel_end = 1'b0;
    case (state)
      ST_IDLE:     if (start) state_nx = ST_LOAD_IMG;
      ST_LOAD_IMG: if (img_last) state_nx = ST_LOAD_KER;
      ST_LOAD_KER: if (ker_last) state_nx = ST_CONV;
      ST_CONV: begin
        if (conv_armed && layer_done) state_nx = ST_DRAIN;
        else if (tmo_hit) kernel_end = 1'b1;
      end
      ST_DRAIN:    if (drain_done) kernel_end = 1'b1;
      ST_FINISH:   state_nx = ST_IDLE;
      default:     state_nx = ST_IDLE;
    endcase
    if (kernel_end) state_nx = last_kernel ? ST_FINISH : ST_LOAD_KER;
  end

  // conv_armed masks layer_done in the first CONV cycle; layer_rst is registered so it cannot glitch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      kidx       <= '0;
      conv_armed <= 1'b0;
      layer_rst  <= 1'b0;
    end else begin
      state      <= state_nx;
      conv_armed <= (state == ST_CONV);
      layer_rst  <= (state_nx == ST_CONV) || (state_nx == ST_DRAIN);
      if (state == ST_IDLE) kidx <= '0;
      else if (kernel_end && !last_kernel) kidx <= kidx + 1'b1;
    end
  end

`ifdef CONV_CTRL_TIMEOUT_EN
  localparam int TW = idx_w(TIMEOUT_CYCLES);
  logic [TW-1:0] tmo_cnt;
  logic          err_q;

  assign tmo_hit = (state == ST_CONV) && !(conv_armed && layer_done) &&
                   (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      tmo_cnt <= (state == ST_CONV) ? tmo_cnt + 1'b1 : '0;
      if (state == ST_IDLE && start) err_q <= 1'b0;
      else if (tmo_hit) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  conv_out_serializer #(
    .DATA_WIDTH(DATA_WIDTH),
    .OROW      (OROW),
    .OCOL      (OCOL)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .active    (state == ST_DRAIN),
    .out_ready (out_ready),
    .conv_out  (layer_conv_out),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .drain_done(drain_done)
  );

  assign out_kidx  = kidx;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_FINISH);
  assign state_dbg = state;

endmodule

// File: tb/tb_conv_layer_ctrl.sv
// Bench for conv_layer_ctrl with a behavioural conv_layer stand-in and a queue-based reference.
module tb_conv_layer_ctrl;
  import cnn_pkg::*;

  localparam int DW = 8, KW = 8, KS = 5, IR = 28, IC = 28, NK = 3, TMO = 100;
  localparam int O_ROWS = IR - KS + 1, O_COLS = IC - KS + 1;
  localparam int NPIX = IR * IC, NKP = KS * KS, NOUT = O_ROWS * O_COLS;
  localparam int LAT = 20;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic pix_in_valid = 1'b0, k_in_valid = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] pix_in_data = '0;
  logic [KW-1:0] k_in_data = '0;
  logic pix_in_ready, k_in_ready, layer_rst, layer_done;
  logic [DW-1:0] layer_image [IR][IC];
  logic [KW-1:0] layer_kernel [KS][KS];
  logic [DW-1:0] layer_conv_out [O_ROWS][O_COLS];
  logic out_valid, out_last, busy, done, err;
  logic [DW-1:0] out_data;
  logic [1:0] out_kidx;
  conv_ctrl_state_t state_dbg;

  always #5 clk = ~clk;

  conv_layer_ctrl #(
    .DATA_WIDTH(DW), .KDATA_WIDTH(KW), .KERNEL_SIZE(KS), .IMGROW(IR), .IMGCOL(IC),
    .NUM_KERNELS(NK), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .pix_in_valid(pix_in_valid), .pix_in_ready(pix_in_ready), .pix_in_data(pix_in_data),
    .k_in_valid(k_in_valid), .k_in_ready(k_in_ready), .k_in_data(k_in_data),
    .layer_image(layer_image), .layer_kernel(layer_kernel), .layer_rst(layer_rst),
    .layer_done(layer_done), .layer_conv_out(layer_conv_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .out_kidx(out_kidx), .busy(busy), .done(done), .err(err), .state_dbg(state_dbg)
  );

  function automatic logic [7:0] relu_sat(input int s);
    if (s < 0) return 8'd0;
    if (s > 255) return 8'd255;
    return 8'(s);
  endfunction

  // ---------------- conv_layer stand-in ----------------
  int cyc = 0, done_cyc = 0, done_pulses = 0, lat = 0, fk_s;
  bit fake_done = 1'b0, force_done = 1'b0, hold_off = 1'b0, cleared = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_pulses <= done_pulses + 1;
    if (!layer_rst) begin
      if (fake_done || lat != 0 || !cleared)
        for (int r = 0; r < O_ROWS; r++)
          for (int c = 0; c < O_COLS; c++) layer_conv_out[r][c] <= '0;
      cleared   <= 1'b1;
      lat       <= 0;
      fake_done <= 1'b0;
    end else if (lat < LAT) begin
      lat <= lat + 1;
    end else if (!fake_done && !hold_off) begin
      for (int r = 0; r < O_ROWS; r++)
        for (int c = 0; c < O_COLS; c++) begin
          fk_s = 0;
          for (int i = 0; i < KS; i++)
            for (int j = 0; j < KS; j++)
              fk_s += int'(layer_image[r+i][c+j]) * int'($signed(layer_kernel[i][j]));
          layer_conv_out[r][c] <= relu_sat(fk_s);
        end
      fake_done <= 1'b1;
      done_cyc  <= cyc + 1;
    end
  end
  assign layer_done = fake_done | force_done;

  // ---------------- scoreboard ----------------
  int n_cmp = 0, n_fail = 0;
  bit exp_err = 1'b0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] img_m [NPIX];
  logic [KW-1:0] ker_m [NK][NKP];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build_expected(input int k);
    int s;
    for (int r = 0; r < O_ROWS; r++)
      for (int c = 0; c < O_COLS; c++) begin
        s = 0;
        for (int i = 0; i < KS; i++)
          for (int j = 0; j < KS; j++)
            s += int'(img_m[(r+i)*IC + c + j]) * int'($signed(ker_m[k][i*KS + j]));
        exp_q.push_back(relu_sat(s));
      end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("start_to_ready", pix_in_ready, 1);
    check("start_busy", busy, 1);
  endtask

  task automatic send_image(input int n, input bit gaps);
    int i = 0, g = 0;
    while (i < n && g < 8 * NPIX) begin
      @(negedge clk); g++;
      pix_in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      pix_in_data  = img_m[i];
      if (pix_in_valid && pix_in_ready) i++;
    end
    @(negedge clk); pix_in_valid = 1'b0;
    if (i < n) check("img_load_bound", i, n);
    if (n == NPIX) begin
      check("img_to_kready", k_in_ready, 1);
      check("img_layer_rst", layer_rst, 0);
    end
  endtask

  task automatic send_kernel(input int k, input bit gaps, input bit poke_done);
    int i = 0, g = 0;
    while (i < NKP && g < 8 * NKP) begin
      @(negedge clk); g++;
      if (g == 1) check("ker_rst_low", layer_rst, 0);
      force_done = poke_done && (i >= 5) && (i < 15);
      k_in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      k_in_data  = ker_m[k][i];
      if (k_in_valid && k_in_ready) i++;
    end
    force_done = 1'b0;
    @(negedge clk); k_in_valid = 1'b0;
    if (i < NKP) check("ker_load_bound", i, NKP);
    check("ker_to_layer_rst", layer_rst, 1);
    check("ker_kready_off", k_in_ready, 0);
  endtask

  task automatic drain_map(input int k, input bit rand_ready, input bit poke_start);
    int got = 0, g = 0, first = -1, last_c = 0;
    bit stalled = 1'b0, held_l = 1'b0;
    logic [DW-1:0] held_d = '0, e;
    while (got < NOUT && g < 4 * NOUT) begin
      @(negedge clk); g++;
      start = poke_start && (g == 3);
      if (poke_start && g == 4) begin
        check("conv_start_busy", busy, 1);
        check("conv_start_ignored", pix_in_ready, 0);
      end
      if (out_valid) begin
        if (first < 0) begin
          first = cyc;
          check("done_to_valid", cyc, done_cyc + 1);
        end
        if (stalled) begin
          check("stall_data", out_data, held_d);
          check("stall_last", out_last, held_l);
          check("stall_kidx", out_kidx, k);
        end
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (out_ready) begin
          e = exp_q.pop_front();
          check("pix_data", out_data, e);
          check("pix_last", out_last, (got == NOUT - 1));
          check("pix_kidx", out_kidx, k);
          got++;
          stalled = 1'b0;
          last_c = cyc;
        end else begin
          stalled = 1'b1;
          held_d  = out_data;
          held_l  = out_last;
        end
      end
    end
    start = 1'b0;
    if (got < NOUT) check("drain_bound", got, NOUT);
    if (!rand_ready) check("drain_cycles", last_c - first + 1, NOUT);
  endtask

  task automatic post_drain(input int k, input bit poke_start);
    @(negedge clk); out_ready = 1'b0;
    if (k < NK - 1) begin
      check("next_kready", k_in_ready, 1);
      check("between_rst_low", layer_rst, 0);
      check("between_no_done", done, 0);
    end else begin
      check("done_pulse", done, 1);
      check("done_busy", busy, 1);
      check("done_err", err, exp_err);
      start = poke_start;
      @(negedge clk); start = 1'b0;
      check("after_done_low", done, 0);
      check("after_idle", busy, 0);
      check("finish_start_ignored", pix_in_ready, 0);
    end
  endtask

  task automatic run_job(input bit gaps, input bit rand_ready, input bit pokes);
    do_start();
    send_image(NPIX, gaps);
    for (int k = 0; k < NK; k++) begin
      send_kernel(k, gaps, pokes && k == 1);
      build_expected(k);
      drain_map(k, rand_ready, pokes && k == 0);
      post_drain(k, pokes);
    end
  endtask

  // ---------------- directed sequence ----------------
  int exp_runs = 0;
  initial begin
    repeat (3) @(negedge clk);
    check("rst_state", state_dbg, ST_IDLE);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_pix_ready", pix_in_ready, 0);
    check("rst_k_ready", k_in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_kidx", out_kidx, 0);
    check("rst_layer_rst", layer_rst, 0);
    check("rst_img_buf", layer_image[27][27], 0);
    check("rst_ker_buf", layer_kernel[4][4], 0);
    rst = 1'b1;

    // all-ones image against kernels of +1, 0 and -1
    for (int i = 0; i < NPIX; i++) img_m[i] = 8'd1;
    for (int j = 0; j < NKP; j++) begin
      ker_m[0][j] = 8'h01;
      ker_m[1][j] = 8'h00;
      ker_m[2][j] = 8'hFF;
    end
    run_job(1'b0, 1'b0, 1'b0); exp_runs++;

    // same data, bursty inputs, random backpressure, stray start and layer_done
    run_job(1'b1, 1'b1, 1'b1); exp_runs++;

    // abandoned load at pixel 300, then a fresh random run
    for (int i = 0; i < NPIX; i++) img_m[i] = 8'($urandom_range(1, 15));
    do_start();
    send_image(300, 1'b1);
    @(negedge clk); rst = 1'b0;
    #1;
    check("mid_rst_state", state_dbg, ST_IDLE);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_pix_ready", pix_in_ready, 0);
    check("mid_rst_img0", layer_image[0][0], 0);
    check("mid_rst_img299", layer_image[10][19], 0);
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < NPIX; i++) img_m[i] = 8'($urandom_range(0, 15));
    for (int k = 0; k < NK; k++)
      for (int j = 0; j < NKP; j++) ker_m[k][j] = 8'(int'($urandom_range(0, 6)) - 3);
    run_job(1'b1, 1'b0, 1'b0); exp_runs++;

`ifdef CONV_CTRL_TIMEOUT_EN
    begin
      int g = 0;
      bit seen = 1'b0;
      do_start();
      send_image(NPIX, 1'b0);
      hold_off = 1'b1;
      send_kernel(0, 1'b0, 1'b0);
      while (!k_in_ready && g < 10 * TMO) begin
        @(negedge clk); g++;
        if (out_valid) seen = 1'b1;
      end
      hold_off = 1'b0;
      exp_err  = 1'b1;
      check("tmo_cycles", g, TMO);
      check("tmo_err", err, 1);
      check("tmo_no_output", seen, 0);
      check("tmo_next_kidx", out_kidx, 1);
      for (int k = 1; k < NK; k++) begin
        send_kernel(k, 1'b0, 1'b0);
        build_expected(k);
        drain_map(k, 1'b0, 1'b0);
        post_drain(k, 1'b0);
      end
      exp_runs++;
    end
`endif

    repeat (2) @(negedge clk);
    check("done_pulse_count", done_pulses, exp_runs);
    check("exp_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
